// File: rtl/line_mem_responder_if.sv
// line_mem_responder_if: request/response channels between a memory requester and the line responder.
interface line_mem_responder_if;
   logic         memreq_val;
   logic         memreq_rdy;
   logic [174:0] memreq_msg;
   logic         memresp_val;
   logic         memresp_rdy;
   logic [144:0] memresp_msg;
   modport master (
      output memreq_val, memreq_msg, memresp_rdy,
      input  memreq_rdy, memresp_val, memresp_msg
   );
   modport slave (
      input  memreq_val, memreq_msg, memresp_rdy,
      output memreq_rdy, memresp_val, memresp_msg
   );
endinterface

// File: rtl/line_mem_responder.sv
// line_mem_responder: single-outstanding 128-bit line memory with a fixed response latency.
module line_mem_responder #(
   parameter int p_num_lines = 64,
   parameter int p_latency   = 2
) (
   input logic                  clk,
   input logic                  reset,
   line_mem_responder_if.slave  mem
);
   localparam int lp_iw = $clog2(p_num_lines);
   localparam logic [3:0] lp_lat = 4'(p_latency - 1);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t             r_state, w_next;
   logic [3:0]         r_cnt;
   logic [127:0]       r_lines [p_num_lines];
   logic [2:0]         r_type;
   logic [7:0]         r_opaque;
   logic [3:0]         r_len;
   logic [127:0]       r_data;
   logic [2:0]         w_type;
   logic [lp_iw-1:0]   w_idx;
   logic               w_accept;
   logic               w_hshake;
   logic               w_unused;
   assign w_type   = mem.memreq_msg[174:172];
   assign w_idx    = mem.memreq_msg[136 +: lp_iw];
   assign w_accept = mem.memreq_val && r_state == IDLE;
   assign w_hshake = mem.memresp_rdy && r_state == RESP;
   assign w_unused = &{1'b0, mem.memreq_msg[163:136+lp_iw], mem.memreq_msg[135:132]};
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      if (w_accept) w_next = (lp_lat == 4'd0) ? RESP : WAIT;
      else if (r_state == WAIT && r_cnt == 4'd1) w_next = RESP;
      else if (w_hshake) w_next = IDLE;
   end
   always_comb begin
      mem.memreq_rdy  = r_state == IDLE;
      mem.memresp_val = r_state == RESP;
      mem.memresp_msg = {r_type, r_opaque, 2'b00, r_len, r_data};
   end
   // Reads capture the line as it was before any write on the same edge (single port).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_type   <= '0;
         r_opaque <= '0;
         r_len    <= '0;
         r_data   <= '0;
         for (int i = 0; i < p_num_lines; i++) r_lines[i] <= '0;
      end else if (w_accept) begin
         r_cnt    <= lp_lat;
         r_type   <= w_type;
         r_opaque <= mem.memreq_msg[171:164];
         r_len    <= mem.memreq_msg[131:128];
         r_data   <= (w_type == 3'd0) ? r_lines[w_idx] : '0;
         if (w_type == 3'd1 || w_type == 3'd2) r_lines[w_idx] <= mem.memreq_msg[127:0];
      end else if (r_state == WAIT) begin
         r_cnt <= r_cnt - 4'd1;
      end
   end
endmodule

// File: doc/line_mem_responder.md
LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 Parameter p_num_lines: default 64. Number of 128-bit lines stored; power of two, 2..256.
REQ-002 Parameter p_latency: default 2. Cycles from request accept to memresp_val; range 1..15.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset; synchronous, active-high.
REQ-005 memreq_val  in  1  request valid.
REQ-006 memreq_rdy  out  1  responder can accept a request.
REQ-007 memreq_msg  in  175  16B request: type[174:172], opaque[171:164], addr[163:132], len[131:128], data[127:0].
REQ-008 memresp_val  out  1  response valid.
REQ-009 memresp_rdy  in  1  consumer accepts response.
REQ-010 memresp_msg  out  145  16B response: type[144:142], opaque[141:134], test[133:132], len[131:128], data[127:0].

Function
REQ-011 The request type encodings SHALL be: 0 read, 1 write, 2 init; 3..7 are unknown.
REQ-012 Storage SHALL be p_num_lines x 128 bits, indexed by addr[4+log2(p_num_lines)-1:4]; upper addr bits and addr[3:0] ignored (aliasing permitted).
REQ-013 FSM states SHALL be IDLE, WAIT, RESP; reset enters IDLE.
REQ-014 memreq_rdy SHALL equal (state==IDLE); a request is accepted on an edge where memreq_val and memreq_rdy are both 1.
REQ-015 On accept: write/init SHALL update the indexed line with data[127:0] at that edge; len ignored, full line always written.
REQ-016 On accept: read SHALL capture the indexed line (pre-write contents, single port) into the response data register at that edge.
REQ-017 On accept: type, opaque, and len SHALL be captured into response registers; test field always 2'b00.
REQ-018 On accept: a latency counter SHALL load p_latency-1; if that is 0, next state = RESP, else next state = WAIT.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 0, so memresp_val first rises exactly p_latency cycles after the accept edge.
REQ-020 RESP SHALL drive memresp_val=1 with memresp_msg stable until memresp_val and memresp_rdy are both 1, then go to IDLE.
REQ-021 No request SHALL be accepted in the cycle a response handshakes; the minimum request-to-request spacing is p_latency+1 cycles.
REQ-022 Write/init response data SHALL be 0; read response data SHALL be the captured line; len SHALL be echoed.
REQ-023 Unknown types SHALL produce a response with type echoed and data 0, and SHALL NOT modify storage.
REQ-024 Exactly one request SHALL be outstanding at any time; responses return in request order.
REQ-025 memresp_msg SHALL be driven from registers only (no combinational path from memreq_msg).

Reset
REQ-026 On reset: state=IDLE, counter=0, all storage lines=0, response registers=0.
REQ-027 Outputs after reset: memreq_rdy=1, memresp_val=0, memresp_msg=0.
REQ-028 Reset asserted in WAIT or RESP SHALL drop the pending response; memresp_val=0 from the next edge, and no handshake is completed.
REQ-029 Reset SHALL override a simultaneous request: no storage write and no accept on that edge.

Verification
REQ-030 Post-reset read: read addr 0x00000040 opaque 0x11 -> after 2 cycles, memresp type=0, opaque=0x11, data=0.
REQ-031 Write then read: write addr 0x00000120 data 0x0123..CDEF, then read same addr -> write response data=0; read response data=0x0123..CDEF, opaque echoed.
REQ-032 Aliasing (p_num_lines=64): write addr 0x00000010, read addr 0x00000410 -> same data returned; addr 0x00000014 also returns it.
REQ-033 Backpressure: hold memresp_rdy=0 for 5 cycles in RESP -> memresp_val stays 1, msg constant, memreq_rdy=0; rdy=1 -> handshake, then IDLE next cycle.
REQ-034 Unknown type 5 to a written line -> response type=5, data=0; a subsequent read returns the unchanged line.
REQ-035 Reset in WAIT after a read accept -> memresp_val never rises; memreq_rdy=1 the cycle after reset; storage reads 0.
